sub: RTL and testbench

SUB -- requirements
Module: sub

---
 rtl/sub.sv | 86 ++++++++
 tb/tb_sub.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub.sv
// ============================================================================
//  Module      : sub
//  Description : Registered WIDTH-bit subtractor with borrow-in, returning the
//                difference, unsigned borrow-out (CF) and signed overflow (OF)
//                one clock after a valid input. Define SUB_ZF_EN to add a
//                registered zero flag (ZF).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] sr,
   input  logic [WIDTH-1:0] tg,
   input  logic             bin,
   output logic [WIDTH-1:0] res,
   output logic             CF,
   output logic             OF,
`ifdef SUB_ZF_EN
   output logic             ZF,
`endif
   output logic             out_valid
);

   logic [WIDTH:0]   w_bin_ext;
   logic [WIDTH:0]   w_diff;
   logic             w_of;

   logic [WIDTH-1:0] r_res;
   logic             r_cf;
   logic             r_of;
   logic             r_valid;

   // The extra top bit of the widened difference is the unsigned borrow-out;
   // tg + bin cannot wrap inside WIDTH+1 bits, so tg = all-ones with bin = 1
   // always borrows.
   assign w_bin_ext = {{WIDTH{1'b0}}, bin};
   assign w_diff    = {1'b0, sr} - {1'b0, tg} - w_bin_ext;

   // With equal operand signs the exact result always fits, even with a
   // borrow-in, so overflow needs differing operand signs and a result whose
   // sign differs from the minuend.
   assign w_of = (sr[WIDTH-1] ^ tg[WIDTH-1]) & (w_diff[WIDTH-1] ^ sr[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res   <= '0;
         r_cf    <= 1'b0;
         r_of    <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_res <= w_diff[WIDTH-1:0];
            r_cf  <= w_diff[WIDTH];
            r_of  <= w_of;
         end
      end
   end

`ifdef SUB_ZF_EN
   logic r_zf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zf <= 1'b0;
      end else if (in_valid) begin
         r_zf <= (w_diff[WIDTH-1:0] == '0);
      end
   end

   assign ZF = r_zf;
`endif

   assign res       = r_res;
   assign CF        = r_cf;
   assign OF        = r_of;
   assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sub.sv
// ============================================================================
//  Module      : tb_sub
//  Description : Scoreboard bench for sub (WIDTH = 32); covers ZF when
//                SUB_ZF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic [31:0] res;
      logic        cf;
      logic        of;
      logic        zf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] sr;
   logic [31:0] tg;
   logic        bin;
   logic [31:0] res;
   logic        CF;
   logic        OF;
   logic        ZF;
   logic        out_valid;

   int   n_tests;
   int   n_fail;
   exp_t sb_q[$];
   exp_t last;
   exp_t e;

   sub #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .sr        (sr),
      .tg        (tg),
      .bin       (bin),
      .res       (res),
      .CF        (CF),
      .OF        (OF),
`ifdef SUB_ZF_EN
      .ZF        (ZF),
`endif
      .out_valid (out_valid)
   );

`ifndef SUB_ZF_EN
   assign ZF = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: exact 64-bit arithmetic on the operands.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
      exp_t        m;
      logic [63:0] u;
      longint      s;
      u     = {32'b0, a} - {32'b0, b} - {63'b0, c};
      m.res = u[31:0];
      m.cf  = ({32'b0, a} < ({32'b0, b} + {63'b0, c}));
      s     = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
      m.of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      m.zf  = (m.res == 32'h0);
      return m;
   endfunction

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
      @(negedge clk);
      in_valid = v;
      sr       = a;
      tg       = b;
      bin      = c;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      sr       = 32'h1234_5678;
      tg       = 32'h0000_0001;
      bin      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_tests++;
      if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", res); end
      n_tests++;
      if (CF !== 1'b0 || OF !== 1'b0) begin n_fail++; $display("FAIL reset_flags got CF=%b OF=%b want 0 0", CF, OF); end
`ifdef SUB_ZF_EN
      n_tests++;
      if (ZF !== 1'b0) begin n_fail++; $display("FAIL reset_zf got %b want 0", ZF); end
`endif
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got %b want 0", out_valid); end
   endtask

   // Spec vectors issued back to back; expectations are the given constants.
   task automatic test_directed();
      logic [31:0] va[9];
      logic [31:0] vb[9];
      logic        vc[9];
      logic [31:0] xr[9];
      logic        xc[9];
      logic        xo[9];
      va = '{32'h5, 32'h5, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h2, 32'h0, 32'h8000_0000, 32'h1234_5678};
      vb = '{32'h2, 32'h5, 32'h2, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF};
      vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      xr = '{32'h3, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
      xc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      xo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, va[i], vb[i], vc[i]);
         e.res = xr[i];
         e.cf  = xc[i];
         e.of  = xo[i];
         e.zf  = (xr[i] == 32'h0);
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_tests++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid got %b want 1", i, out_valid); end
         n_tests++;
         if (res !== e.res) begin n_fail++; $display("FAIL dir%0d_res got %h want %h", i, res, e.res); end
         n_tests++;
         if (CF !== e.cf || OF !== e.of) begin
            n_fail++; $display("FAIL dir%0d_flags got CF=%b OF=%b want CF=%b OF=%b", i, CF, OF, e.cf, e.of);
         end
`ifdef SUB_ZF_EN
         n_tests++;
         if (ZF !== e.zf) begin n_fail++; $display("FAIL dir%0d_zf got %b want %b", i, ZF, e.zf); end
`endif
         last = e;
      end
   endtask

   // Random stream with random gaps: valid cycles pop the scoreboard,
   // idle cycles (with changing operands) must hold the previous result.
   task automatic test_back_to_back();
      logic v;
      for (int i = 0; i < 60; i++) begin
         v = (i < 3) ? 1'b1 : (i == 3) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
         drive(v, $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom));
         if (v) sb_q.push_back(model(sr, tg, bin));
         @(posedge clk);
         #1;
         n_tests++;
         if (out_valid !== v) begin n_fail++; $display("FAIL b2b%0d_valid got %b want %b", i, out_valid, v); end
         if (v) begin
            e    = sb_q.pop_front();
            last = e;
         end else begin
            e = last;
         end
         n_tests++;
         if (res !== e.res || CF !== e.cf || OF !== e.of) begin
            n_fail++;
            $display("FAIL b2b%0d_out got %h/%b/%b want %h/%b/%b", i, res, CF, OF, e.res, e.cf, e.of);
         end
`ifdef SUB_ZF_EN
         n_tests++;
         if (ZF !== e.zf) begin n_fail++; $display("FAIL b2b%0d_zf got %b want %b", i, ZF, e.zf); end
`endif
      end
   endtask

   task automatic test_midstream_reset();
      drive(1'b1, 32'h0000_0009, 32'h0000_0004, 1'b0);
      sb_q.push_back(model(sr, tg, bin));
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || res !== e.res) begin
         n_fail++; $display("FAIL mid_pre got valid=%b res=%h want 1 %h", out_valid, res, e.res);
      end
      drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || res !== 32'h0 || CF !== 1'b0 || OF !== 1'b0 || ZF !== 1'b0) begin
         n_fail++; $display("FAIL mid_async got valid=%b res=%h CF=%b OF=%b want all 0", out_valid, res, CF, OF);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || res !== 32'h0) begin
         n_fail++; $display("FAIL mid_held got valid=%b res=%h want 0 0", out_valid, res);
      end
      drive(1'b0, 32'hDEAD_BEEF, 32'h1, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || res !== 32'h0) begin
         n_fail++; $display("FAIL mid_release got valid=%b res=%h want 0 0", out_valid, res);
      end
      drive(1'b1, 32'h0000_0001, 32'h0000_0003, 1'b1);
      sb_q.push_back(model(sr, tg, bin));
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || res !== e.res || CF !== e.cf || OF !== e.of) begin
         n_fail++;
         $display("FAIL mid_resume got %b %h/%b/%b want 1 %h/%b/%b", out_valid, res, CF, OF, e.res, e.cf, e.of);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      last     = '0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      sr       = '0;
      tg       = '0;
      bin      = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_midstream_reset();
      n_tests++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty got %0d want 0", sb_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
